vsq_mac_acc: RTL and testbench

Pipelined, parametrised multi-mode MAC accumulator. It is the sequential successor of the combinational dot-product MAC in the PE datapath. It accepts a stream of vector chunks with a valid/ready handshake and computes per-chunk dot products in INT8, INT4 or INT4_VSQ. It accumulates chunks internally until a beat flagged `i_last`, then emits one saturated result per group through a valid/ready output register.

---
 rtl/vsq_mac_acc_if.sv | 29 ++
 rtl/vsq_mac_acc.sv | 102 ++++++++++
 tb/tb_vsq_mac_acc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vsq_mac_acc_if.sv
// vsq_mac_acc_if: beat-in / result-out handshake bundle for vsq_mac_acc
//   slave  (DUT side): takes i_valid/i_last/i_mode/i_a/i_b/i_scale_a/i_scale_b/i_ready,
//                      drives o_ready/o_valid/o_result/o_sat
//   master (source/sink side): the mirror image
interface vsq_mac_acc_if #(
  parameter int LANES = 32,
  parameter int ACC_W = 24
);
  logic                    i_valid;
  logic                    o_ready;
  logic                    i_last;
  logic [1:0]              i_mode;
  logic [8*LANES-1:0]      i_a;
  logic [8*LANES-1:0]      i_b;
  logic [7:0]              i_scale_a;
  logic [7:0]              i_scale_b;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [ACC_W-1:0] o_result;
  logic                    o_sat;
  modport slave (
    input  i_valid, i_last, i_mode, i_a, i_b, i_scale_a, i_scale_b, i_ready,
    output o_ready, o_valid, o_result, o_sat
  );
  modport master (
    output i_valid, i_last, i_mode, i_a, i_b, i_scale_a, i_scale_b, i_ready,
    input  o_ready, o_valid, o_result, o_sat
  );
endinterface

// File: rtl/vsq_mac_acc.sv
// vsq_mac_acc: pipelined INT8/INT4/INT4_VSQ dot-product accumulator with per-group saturated result
//   i_clk, i_rst_n (async, active-low); bus: vsq_mac_acc_if.slave (beat stream in, group result out)
//   Stage 1 registers the per-beat product, stage 2 accumulates, output register holds the result.
//   Define VSQ_MAC_SAT_EN to clamp INT8/INT4 overflow; otherwise those modes wrap (INT4_VSQ always clamps).
module vsq_mac_acc #(
  parameter int LANES = 32,
  parameter int ACC_W = 24
) (
  input logic          i_clk,
  input logic          i_rst_n,
  vsq_mac_acc_if.slave bus
);
  localparam int PW = ACC_W + 1;
`ifdef VSQ_MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic adv;
  logic signed [15:0]   p8;
  logic signed [7:0]    p4;
  logic [7:0]           s;
  logic signed [PW-1:0] sum8, sum4, prod, sum;
  logic signed [ACC_W-1:0] base, nxt, clampv;
  logic ovf, base_sat;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_clamp_q, s1_clamp_d;
  logic signed [PW-1:0] s1_prod_q, s1_prod_d;
  logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, sticky_q, sticky_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, o_result_q, o_result_d;
  logic o_valid_q, o_valid_d, o_sat_q, o_sat_d;
  assign adv = ~o_valid_q | bus.i_ready;
  always_comb begin
    sum8 = '0;
    sum4 = '0;
    p8 = '0;
    p4 = '0;
    for (int i = 0; i < LANES; i++) begin
      p8 = $signed(bus.i_a[8*i +: 8]) * $signed(bus.i_b[8*i +: 8]);
      sum8 = sum8 + PW'(p8);
    end
    for (int i = 0; i < 2*LANES; i++) begin
      p4 = $signed(bus.i_a[4*i +: 4]) * $signed(bus.i_b[4*i +: 4]);
      sum4 = sum4 + PW'(p4);
    end
    // rounded scale product; the dropped <<8 is restored downstream
    s = 8'((bus.i_scale_a * bus.i_scale_b + 16'd128) >> 8);
    prod = bus.i_mode == 2'd0 ? sum8 :
           bus.i_mode == 2'd1 ? sum4 :
           bus.i_mode == 2'd2 ? PW'(sum4 * $signed({1'b0, s})) : '0;
  end
  always_comb begin
    // a completed group in stage 2 means the next beat starts from zero
    base = s2_last_q ? '0 : acc_q;
    base_sat = ~s2_last_q & sticky_q;
    sum = PW'(base) + s1_prod_q;
    ovf = sum[ACC_W] ^ sum[ACC_W-1];
    clampv = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    nxt = (ovf & s1_clamp_q) ? clampv : sum[ACC_W-1:0];
    s1_valid_d = adv ? bus.i_valid : s1_valid_q;
    s1_last_d = adv ? bus.i_last : s1_last_q;
    s1_clamp_d = adv ? (SAT_EN | (bus.i_mode == 2'd2)) : s1_clamp_q;
    s1_prod_d = adv ? prod : s1_prod_q;
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    s2_last_d = adv ? (s1_valid_q & s1_last_q) : s2_last_q;
    acc_d = adv ? (s1_valid_q ? nxt : base) : acc_q;
    sticky_d = adv ? (s1_valid_q ? (base_sat | ovf) : base_sat) : sticky_q;
    o_valid_d = (adv & s2_valid_q & s2_last_q) | (o_valid_q & ~bus.i_ready);
    o_result_d = (adv & s2_valid_q & s2_last_q) ? acc_q : o_result_q;
    o_sat_d = (adv & s2_valid_q & s2_last_q) ? sticky_q : o_sat_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_clamp_q <= 1'b0;
      s1_prod_q <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q <= 1'b0;
      acc_q <= '0;
      sticky_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_result_q <= '0;
      o_sat_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      s1_clamp_q <= s1_clamp_d;
      s1_prod_q <= s1_prod_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q <= s2_last_d;
      acc_q <= acc_d;
      sticky_q <= sticky_d;
      o_valid_q <= o_valid_d;
      o_result_q <= o_result_d;
      o_sat_q <= o_sat_d;
    end
  end
  assign bus.o_ready = adv;
  assign bus.o_valid = o_valid_q;
  assign bus.o_result = o_result_q;
  assign bus.o_sat = o_sat_q;
endmodule

// File: tb/tb_vsq_mac_acc.sv
// tb_vsq_mac_acc: directed self-checking bench for vsq_mac_acc (LANES=32, ACC_W=24)
module tb_vsq_mac_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int res_q[$];
  bit sat_q[$];
  int lat;
`ifdef VSQ_MAC_SAT_EN
  localparam int OVF17 = 8388607;
`else
  localparam int OVF17 = -7864320;
`endif
  always #5 clk = ~clk;
  vsq_mac_acc_if #(.LANES(32), .ACC_W(24)) bus ();
  vsq_mac_acc #(.LANES(32), .ACC_W(24)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.o_valid && bus.i_ready) begin
      res_q.push_back(int'(bus.o_result));
      sat_q.push_back(bus.o_sat);
    end
  end
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] sa, input logic [7:0] sb, input logic last);
    int n = 0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_mode = m;
    bus.i_a = {32{a}};
    bus.i_b = {32{b}};
    bus.i_scale_a = sa;
    bus.i_scale_b = sb;
    bus.i_last = last;
    #2;
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!bus.o_ready) check("send_ready", bus.o_ready, 1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask
  task automatic expect_res(input string tag, input int exp, input bit exp_sat);
    int n = 0;
    while (res_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, res_q.size() > 0, 1);
    if (res_q.size() > 0) begin
      check(tag, res_q.pop_front(), exp);
      check({tag, "_sat"}, sat_q.pop_front(), exp_sat);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    bus.i_valid = 1'b0;
    bus.i_last = 1'b0;
    bus.i_mode = 2'd0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_scale_a = '0;
    bus.i_scale_b = '0;
    bus.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_result", bus.o_result, 0);
    check("rst_sat", bus.o_sat, 0);
    check("rst_ready", bus.o_ready, 1);
    rst_n = 1'b1;
    send(2'd0, 8'h01, 8'h02, 8'd0, 8'd0, 1'b1);
    lat = 0;
    for (int i = 0; i < 10 && !bus.o_valid; i++) begin
      @(negedge clk);
      lat++;
    end
    check("int8_lat", lat, 3);
    expect_res("int8", 64, 0);
    send(2'd1, 8'h11, 8'hFF, 8'd0, 8'd0, 1'b0);
    send(2'd1, 8'h11, 8'hFF, 8'd0, 8'd0, 1'b0);
    send(2'd1, 8'h11, 8'hFF, 8'd0, 8'd0, 1'b1);
    repeat (6) @(negedge clk);
    check("int4_pulses", res_q.size(), 1);
    expect_res("int4", -192, 0);
    send(2'd2, 8'h77, 8'h77, 8'd128, 8'd128, 1'b0);
    send(2'd2, 8'h77, 8'h77, 8'd128, 8'd128, 1'b1);
    expect_res("vsq", 401408, 0);
    for (int i = 0; i < 17; i++) send(2'd0, 8'h80, 8'h80, 8'd0, 8'd0, i == 16);
    expect_res("int8_ovf", OVF17, 1);
    for (int i = 0; i < 9; i++) send(2'd2, 8'h88, 8'h88, 8'd255, 8'd255, i == 8);
    expect_res("vsq_sat", 8388607, 1);
    send(2'd3, 8'h80, 8'h80, 8'd0, 8'd0, 1'b0);
    send(2'd1, 8'h11, 8'h11, 8'd0, 8'd0, 1'b0);
    send(2'd0, 8'h01, 8'h02, 8'd0, 8'd0, 1'b1);
    expect_res("mixed", 128, 0);
    send(2'd3, 8'h7F, 8'h7F, 8'd0, 8'd0, 1'b1);
    expect_res("mode3", 0, 0);
    bus.i_ready = 1'b0;
    send(2'd0, 8'h01, 8'h03, 8'd0, 8'd0, 1'b1);
    repeat (3) @(negedge clk);
    check("bp_valid", bus.o_valid, 1);
    fork
      begin
        send(2'd0, 8'h01, 8'h01, 8'd0, 8'd0, 1'b0);
        send(2'd0, 8'h01, 8'h01, 8'd0, 8'd0, 1'b1);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          #2;
          check("bp_ready", bus.o_ready, 0);
          check("bp_hold", bus.o_result, 96);
        end
        @(negedge clk);
        bus.i_ready = 1'b1;
      end
    join
    expect_res("bp_first", 96, 0);
    expect_res("bp_second", 64, 0);
    send(2'd0, 8'h01, 8'h02, 8'd0, 8'd0, 1'b0);
    send(2'd0, 8'h01, 8'h02, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", bus.o_valid, 0);
    rst_n = 1'b1;
    send(2'd0, 8'h01, 8'h02, 8'd0, 8'd0, 1'b1);
    expect_res("rst_fresh", 64, 0);
    repeat (5) @(negedge clk);
    check("rst_no_stale", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
